// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a parity check and STATUS[4].
module uart_rx #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] addr,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rx
);

    localparam int DIV_RAW = CLK_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
    localparam int CW      = $clog2(DIV) + 1;
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       rx_prev_reg;
    logic       rx_s;
    logic       fall_edge;

    assign rx_s      = sync_reg[1];
    assign fall_edge = rx_prev_reg & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[0], rx};
            rx_prev_reg <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic [2:0]      bit_reg, bit_next;
    logic            par_bad_reg, par_bad_next;
    logic            expire;
    logic            push;
    logic            set_frame;
    logic            set_par;

    assign expire = (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            bit_reg     <= '0;
            par_bad_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            bit_reg     <= bit_next;
            par_bad_reg <= par_bad_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = expire ? cnt_reg : cnt_reg - CW'(1);
        shift_next   = shift_reg;
        bit_next     = bit_reg;
        par_bad_next = par_bad_reg;
        push         = 1'b0;
        set_frame    = 1'b0;
        set_par      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (fall_edge) begin
                    state_next = S_START;
                    cnt_next   = CNT_HALF;
                end
            end

            S_START: begin
                if (expire) begin
                    if (!rx_s) begin
                        state_next   = S_DATA;
                        cnt_next     = CNT_FULL;
                        bit_next     = 3'd0;
                        par_bad_next = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (expire) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    cnt_next   = CNT_FULL;
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                // Even parity: data bits plus parity bit must hold an even number of ones.
                if (expire) begin
                    par_bad_next = (^shift_reg) ^ rx_s;
                    cnt_next     = CNT_FULL;
                    state_next   = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (expire) begin
                    set_par = par_bad_reg;
                    if (rx_s) begin
                        push       = ~par_bad_reg;
                        state_next = S_IDLE;
                    end else begin
                        set_frame  = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // A low line here is a break, not a new start bit.
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        empty;
    logic        full;
    logic        sel_data;
    logic        sel_status;
    logic        pop;
    logic        push_ok;
    logic        ovr_set;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign sel_data   = (addr[2:0] == ADDR_DATA);
    assign sel_status = (addr[2:0] == ADDR_STATUS);

    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign pop     = rd_en & sel_data & ~empty;
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags (set wins over a simultaneous clear)
    // ------------------------------------------------------------------
    logic ovr_reg;
    logic frame_reg;
    logic par_err;
    logic clr;

    assign clr = wr_en & sel_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_reg   <= 1'b0;
            frame_reg <= 1'b0;
        end else begin
            ovr_reg   <= ovr_set   | (ovr_reg   & ~(clr & wr_data[2]));
            frame_reg <= set_frame | (frame_reg & ~(clr & wr_data[3]));
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_reg <= 1'b0;
        end else begin
            par_err_reg <= set_par | (par_err_reg & ~(clr & wr_data[4]));
        end
    end

    assign par_err = par_err_reg;

    logic unused_bits;
    assign unused_bits = &{1'b0, addr[4:3], wr_data[7:5], wr_data[1:0]};
`else
    assign par_err = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, addr[4:3], wr_data[7:4], wr_data[1:0], set_par};
`endif

    // ------------------------------------------------------------------
    // Bus read path
    // ------------------------------------------------------------------
    logic [7:0] status;
    logic [7:0] rd_mux;
    logic [7:0] rd_data_reg;
    logic       rd_valid_reg;

    assign status = {3'b000, par_err, frame_reg, ovr_reg, full, ~empty};

    always_comb begin
        rd_mux = 8'h00;
        if (sel_data) begin
            rd_mux = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
        end else if (sel_status) begin
            rd_mux = status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= 8'h00;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_data_reg <= rd_mux;
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule
